// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter that gives each requesting drawing
// engine one exclusive pixel burst per frame on the shared frame-buffer write
// port. Starting priority rotates across frames via a persistent pointer.
module fb_write_arbiter #(
  parameter int unsigned NUM_SOURCES      = 4,
  parameter int unsigned DRAW_WIDTH       = 640,
  parameter int unsigned DRAW_HEIGHT      = 480,
  parameter int unsigned COLOR_DEPTH      = 9,
  parameter int unsigned MAX_BURST_CYCLES = 4096,
  localparam int unsigned XW = $clog2(DRAW_WIDTH),
  localparam int unsigned YW = $clog2(DRAW_HEIGHT)
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           frame,
  input  logic [NUM_SOURCES-1:0]         src_req,
  input  logic [NUM_SOURCES-1:0]         src_valid,
  input  logic [NUM_SOURCES-1:0]         src_last,
  input  logic [NUM_SOURCES*XW-1:0]      src_x,
  input  logic [NUM_SOURCES*YW-1:0]      src_y,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
  output logic [NUM_SOURCES-1:0]         src_grant,
  output logic [XW-1:0]                  fb_x,
  output logic [YW-1:0]                  fb_y,
  output logic [COLOR_DEPTH-1:0]         fb_color,
  output logic                           fb_we,
  output logic                           fb_busy,
  output logic                           frame_done,
  output logic                           err_timeout,
  output logic                           err_overrun
);

  localparam int unsigned PW = $clog2(NUM_SOURCES);
  localparam int unsigned CW = $clog2(MAX_BURST_CYCLES);

  typedef enum logic [2:0] {IDLE, ARB, GRANT, BURST, GAP, DONE} state_t;

  state_t                   state, state_nxt;
  logic [PW-1:0]            rr_ptr, rr_nxt;
  logic [PW-1:0]            idx, idx_nxt;
  logic [NUM_SOURCES-1:0]   served, served_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;

  logic [NUM_SOURCES-1:0]   grant_nxt;
  logic [XW-1:0]            x_nxt;
  logic [YW-1:0]            y_nxt;
  logic [COLOR_DEPTH-1:0]   color_nxt;
  logic                     we_nxt, busy_nxt, done_nxt, to_nxt, ov_nxt;

  logic [NUM_SOURCES-1:0]   cand;
  logic                     found;
  logic [PW-1:0]            pick, scan;

  logic                     sel_valid, sel_last;
  logic [XW-1:0]            sel_x;
  logic [YW-1:0]            sel_y;
  logic [COLOR_DEPTH-1:0]   sel_color;

  assign cand = src_req & ~served;

  // Rotating-priority search: first unserved requester starting at rr_ptr
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      scan = PW'((32'(rr_ptr) + k) % NUM_SOURCES);
      if (!found && cand[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // Select the granted source's pixel inputs; all other sources are ignored
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (idx == PW'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_x     = src_x[i*XW +: XW];
        sel_y     = src_y[i*YW +: YW];
        sel_color = src_color[i*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    idx_nxt    = idx;
    served_nxt = served;
    cnt_nxt    = cnt;
    x_nxt      = fb_x;
    y_nxt      = fb_y;
    color_nxt  = fb_color;
    we_nxt     = 1'b0;
    to_nxt     = err_timeout;
    ov_nxt     = err_overrun | (frame && (state != IDLE));

    unique case (state)
      IDLE: begin
        if (frame) begin
          state_nxt  = ARB;
          served_nxt = '0;
        end
      end
      ARB: begin
        if (found) begin
          idx_nxt   = pick;
          state_nxt = GRANT;
        end else begin
          state_nxt = DONE;
        end
      end
      GRANT: begin
        cnt_nxt   = '0;
        state_nxt = BURST;
      end
      BURST: begin
        cnt_nxt = cnt + 1'b1;
        if (sel_valid) begin
          we_nxt    = 1'b1;
          x_nxt     = sel_x;
          y_nxt     = sel_y;
          color_nxt = sel_color;
        end
        // Burst ends on an accepted last pixel or when the watchdog expires
        if ((sel_valid && sel_last) || (cnt == CW'(MAX_BURST_CYCLES - 1))) begin
          served_nxt[idx] = 1'b1;
          rr_nxt          = (idx == PW'(NUM_SOURCES - 1)) ? '0 : idx + 1'b1;
          state_nxt       = GAP;
          if (!(sel_valid && sel_last)) begin
            to_nxt = 1'b1;
          end
        end
      end
      GAP:     state_nxt = ARB;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    grant_nxt = ((state_nxt == GRANT) || (state_nxt == BURST))
                ? (NUM_SOURCES'(1) << idx_nxt) : '0;
    busy_nxt  = (state_nxt == GRANT) || (state_nxt == BURST) || (state_nxt == GAP);
    done_nxt  = (state_nxt == DONE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      idx         <= '0;
      served      <= '0;
      cnt         <= '0;
      src_grant   <= '0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_color    <= '0;
      fb_we       <= 1'b0;
      fb_busy     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      idx         <= idx_nxt;
      served      <= served_nxt;
      cnt         <= cnt_nxt;
      src_grant   <= grant_nxt;
      fb_x        <= x_nxt;
      fb_y        <= y_nxt;
      fb_color    <= color_nxt;
      fb_we       <= we_nxt;
      fb_busy     <= busy_nxt;
      frame_done  <= done_nxt;
      err_timeout <= to_nxt;
      err_overrun <= ov_nxt;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter: table of per-burst records plus a
// hand-written mid-burst reset sequence; pixels checked via a scoreboard.
module tb_fb_write_arbiter;

  localparam int unsigned NS     = 4;
  localparam int unsigned XW     = 10;
  localparam int unsigned YW     = 9;
  localparam int unsigned CD     = 9;
  localparam int unsigned MAX_BC = 16;

  logic              clk = 1'b0;
  logic              resetN;
  logic              frame;
  logic [NS-1:0]     src_req, src_valid, src_last;
  logic [NS*XW-1:0]  src_x;
  logic [NS*YW-1:0]  src_y;
  logic [NS*CD-1:0]  src_color;
  logic [NS-1:0]     src_grant;
  logic [XW-1:0]     fb_x;
  logic [YW-1:0]     fb_y;
  logic [CD-1:0]     fb_color;
  logic              fb_we, fb_busy, frame_done, err_timeout, err_overrun;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .NUM_SOURCES(NS), .DRAW_WIDTH(640), .DRAW_HEIGHT(480),
    .COLOR_DEPTH(CD), .MAX_BURST_CYCLES(MAX_BC)
  ) dut (
    .clk(clk), .resetN(resetN), .frame(frame),
    .src_req(src_req), .src_valid(src_valid), .src_last(src_last),
    .src_x(src_x), .src_y(src_y), .src_color(src_color),
    .src_grant(src_grant), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .fb_we(fb_we), .fb_busy(fb_busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CD-1:0] c;
  } pix_t;

  typedef struct {
    logic [NS-1:0] req;
    int            src;
    int            npix;
    int            hold_at;
    int            hold_len;
    bit            send_last;
    bit            new_frame;
    bit            end_frame;
    int            frame_at;
    bit            exp_to;
    bit            exp_ov;
  } vec_t;

  pix_t sb[$];
  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare write port against the scoreboard head (or expect no write)
  task automatic chk_pix(input bit expect_we);
    pix_t p;
    if (expect_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=write expected=queued pixel at %0t", $time);
      end else begin
        p = sb.pop_front();
        chk("fb_we", 32'(fb_we), 32'(1));
        chk("fb_x", 32'(fb_x), 32'(p.x));
        chk("fb_y", 32'(fb_y), 32'(p.y));
        chk("fb_color", 32'(fb_color), 32'(p.c));
      end
    end else begin
      chk("fb_we_idle", 32'(fb_we), 32'(0));
    end
  endtask

  // Random activity on every non-granted source; must be ignored
  task automatic drive_noise(input int s);
    for (int o = 0; o < int'(NS); o++) begin
      if (o != s) begin
        src_valid[o]         = 1'($urandom_range(0, 1));
        src_last[o]          = 1'($urandom_range(0, 1));
        src_x[o*XW +: XW]    = XW'($urandom);
        src_y[o*YW +: YW]    = YW'($urandom);
        src_color[o*CD +: CD] = CD'($urandom);
      end
    end
  endtask

  // Entered in ARB; walks GRANT, BURST cycles and GAP; leaves in next ARB
  task automatic do_burst(input vec_t v);
    pix_t          p;
    logic [NS-1:0] oh;
    int            j, held, bcyc;
    bit            ended, sent, lastd, fpulsed;
    oh = NS'(1) << v.src;
    j = 0; held = 0; bcyc = 0; ended = 0; fpulsed = 0;
    src_req = v.req;
    drive_noise(v.src);
    src_valid[v.src] = 1'b0;
    src_last[v.src]  = 1'b0;
    step();
    chk("grant_at_grant", 32'(src_grant), 32'(oh));
    chk("busy_at_grant", 32'(fb_busy), 32'(1));
    chk_pix(1'b0);
    drive_noise(v.src);
    step();
    chk("grant_burst_entry", 32'(src_grant), 32'(oh));
    chk("busy_burst_entry", 32'(fb_busy), 32'(1));
    chk_pix(1'b0);
    while (!ended) begin
      bcyc++;
      sent  = 1'b0;
      lastd = 1'b0;
      drive_noise(v.src);
      frame = 1'b0;
      if (v.frame_at >= 0 && j == v.frame_at && !fpulsed) begin
        frame   = 1'b1;
        fpulsed = 1'b1;
      end
      if (j == v.hold_at && held < v.hold_len) begin
        held++;
        src_valid[v.src] = 1'b0;
        src_last[v.src]  = 1'($urandom_range(0, 1));
      end else if (j < v.npix) begin
        p.x = XW'($urandom);
        p.y = YW'($urandom);
        p.c = CD'($urandom);
        lastd = v.send_last && (j == v.npix - 1);
        src_valid[v.src]            = 1'b1;
        src_last[v.src]             = lastd;
        src_x[v.src*XW +: XW]       = p.x;
        src_y[v.src*YW +: YW]       = p.y;
        src_color[v.src*CD +: CD]   = p.c;
        sb.push_back(p);
        sent = 1'b1;
        j++;
      end else begin
        src_valid[v.src] = 1'b0;
        src_last[v.src]  = 1'b0;
      end
      ended = lastd || (bcyc == int'(MAX_BC));
      step();
      frame = 1'b0;
      chk_pix(sent);
      chk("grant_burst", 32'(src_grant), ended ? 32'(0) : 32'(oh));
      chk("busy_burst", 32'(fb_busy), 32'(1));
    end
    src_valid = '0;
    src_last  = '0;
    step();
    chk("grant_after_gap", 32'(src_grant), 32'(0));
    chk("busy_after_gap", 32'(fb_busy), 32'(0));
    chk_pix(1'b0);
    chk("err_timeout", 32'(err_timeout), 32'(v.exp_to));
    chk("err_overrun", 32'(err_overrun), 32'(v.exp_ov));
  endtask

  // Entered in ARB with nothing left to serve: expect one DONE pulse
  task automatic expect_done();
    step();
    chk("frame_done_pulse", 32'(frame_done), 32'(1));
    chk("busy_done", 32'(fb_busy), 32'(0));
    chk("grant_done", 32'(src_grant), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frame_done_low", 32'(frame_done), 32'(0));
      chk("busy_idle", 32'(fb_busy), 32'(0));
      chk("grant_idle", 32'(src_grant), 32'(0));
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.new_frame) begin
      src_req = v.req;
      frame   = 1'b1;
      step();
      frame = 1'b0;
      chk("grant_arb", 32'(src_grant), 32'(0));
      chk("busy_arb", 32'(fb_busy), 32'(0));
    end
    do_burst(v);
    if (v.end_frame) expect_done();
  endtask

  initial begin
    //            req      src npix hold len last new end fat  to ov
    vecs[0]  = '{4'b0101, 0, 3,  -1, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0101, 2, 3,  -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0};
    vecs[2]  = '{4'b1111, 3, 3,  -1, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 0, 2,  -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 1, 4,   1, 5, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 2, 1,  -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0};
    vecs[6]  = '{4'b0010, 1, 2,  -1, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0011, 0, 3,  -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 1, 16, -1, 0, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0};
    vecs[9]  = '{4'b0110, 2, 2,  -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0};
    vecs[10] = '{4'b0001, 0, 4,  -1, 0, 1'b1, 1'b1, 1'b1,  2, 1'b1, 1'b1};
    vecs[11] = '{4'b1111, 0, 2,  -1, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0};
    vecs[12] = '{4'b1111, 1, 1,  -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[13] = '{4'b1111, 2, 1,  -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[14] = '{4'b1111, 3, 2,  -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0};

    resetN = 1'b0; frame = 1'b0; src_req = '0; src_valid = '0; src_last = '0;
    src_x = '0; src_y = '0; src_color = '0;
    step();
    step();
    chk("rst_grant", 32'(src_grant), 32'(0));
    chk("rst_fb_x", 32'(fb_x), 32'(0));
    chk("rst_fb_y", 32'(fb_y), 32'(0));
    chk("rst_fb_color", 32'(fb_color), 32'(0));
    chk("rst_fb_we", 32'(fb_we), 32'(0));
    chk("rst_busy", 32'(fb_busy), 32'(0));
    chk("rst_done", 32'(frame_done), 32'(0));
    chk("rst_timeout", 32'(err_timeout), 32'(0));
    chk("rst_overrun", 32'(err_overrun), 32'(0));
    resetN = 1'b1;
    step();
    chk("idle_busy", 32'(fb_busy), 32'(0));

    for (int i = 0; i <= 10; i++) run_vec(vecs[i]);

    // Mid-burst reset: src2 granted (rr_ptr=1, req 1100), one pixel, then reset
    src_req = 4'b1100;
    frame   = 1'b1;
    step();
    frame = 1'b0;
    step();
    chk("rst_seq_grant", 32'(src_grant), 32'(4'b0100));
    step();
    begin
      pix_t p;
      p.x = XW'($urandom); p.y = YW'($urandom); p.c = CD'($urandom);
      src_valid[2] = 1'b1;
      src_x[2*XW +: XW] = p.x; src_y[2*YW +: YW] = p.y; src_color[2*CD +: CD] = p.c;
      sb.push_back(p);
    end
    step();
    chk_pix(1'b1);
    resetN = 1'b0;
    step();
    chk("midrst_grant", 32'(src_grant), 32'(0));
    chk("midrst_we", 32'(fb_we), 32'(0));
    chk("midrst_busy", 32'(fb_busy), 32'(0));
    chk("midrst_timeout", 32'(err_timeout), 32'(0));
    chk("midrst_overrun", 32'(err_overrun), 32'(0));
    resetN = 1'b1;
    src_valid = '0;
    step();
    chk("postrst_grant", 32'(src_grant), 32'(0));
    chk("postrst_we", 32'(fb_we), 32'(0));

    for (int i = 11; i <= 14; i++) run_vec(vecs[i]);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
